// File: rtl/bp_stall_hist_counters.sv
// Saturating stall-reason histogram for the BlackParrot profiler stream,
// read back by the host through a single-outstanding valid/ready port.
module bp_stall_hist_counters #(
   parameter int num_reasons_p = 30,
   parameter int cnt_width_p   = 32,
   parameter int addr_width_p  = 6
) (
   input  logic                    clk_i,
   input  logic                    reset_li,
   input  logic                    en_i,
   input  logic                    clear_i,
   input  logic                    sample_v_i,
   input  logic                    instret_i,
   input  logic [4:0]              reason_i,
   input  logic                    rd_v_i,
   input  logic [addr_width_p-1:0] rd_addr_i,
   output logic                    rd_ready_o,
   output logic                    rd_data_v_o,
   output logic [31:0]             rd_data_o,
   input  logic                    rd_yumi_i
);

   localparam int idx_w_lp = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1;
   localparam logic [cnt_width_p-1:0] max_lp = '1;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

   logic [cnt_width_p-1:0] reason_q [num_reasons_p];
   logic [cnt_width_p-1:0] reason_d [num_reasons_p];
   logic [cnt_width_p-1:0] instr_q, instr_d;
   logic [cnt_width_p-1:0] total_q, total_d;
   logic [idx_w_lp-1:0]    reason_idx;
   logic [31:0]            rd_word;
   logic [31:0]            rd_data_q, rd_data_d;
   state_e                 state_q, state_d;

   function automatic logic [cnt_width_p-1:0] sat_inc(
      input logic [cnt_width_p-1:0] v
   );
      return (v == max_lp) ? v : v + 1'b1;
   endfunction

   // Out-of-range reasons fold into the "unknown" bin
   always_comb begin
      reason_idx = '0;
      if (int'(reason_i) < num_reasons_p)
         reason_idx = reason_i[idx_w_lp-1:0];
   end

   always_comb begin
      reason_d = reason_q;
      instr_d  = instr_q;
      total_d  = total_q;
      if (clear_i) begin
         for (int i = 0; i < num_reasons_p; i++)
            reason_d[i] = '0;
         instr_d = '0;
         total_d = '0;
      end else if (sample_v_i & en_i) begin
         total_d = sat_inc(total_q);
         if (instret_i)
            instr_d = sat_inc(instr_q);
         else
            reason_d[reason_idx] = sat_inc(reason_q[reason_idx]);
      end
   end

   always_comb begin
      rd_word = '0;
      if (int'(rd_addr_i) < num_reasons_p)
         rd_word = 32'(reason_q[rd_addr_i[idx_w_lp-1:0]]);
      else if (rd_addr_i == addr_width_p'(30))
         rd_word = 32'(instr_q);
      else if (rd_addr_i == addr_width_p'(31))
         rd_word = 32'(total_q);
   end

   always_comb begin
      state_d     = state_q;
      rd_data_d   = rd_data_q;
      rd_ready_o  = 1'b0;
      rd_data_v_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            rd_ready_o = 1'b1;
            if (rd_v_i) begin
               rd_data_d = rd_word;
               state_d   = RESP;
            end
         end
         RESP: begin
            rd_data_v_o = 1'b1;
            if (rd_yumi_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         for (int i = 0; i < num_reasons_p; i++)
            reason_q[i] <= '0;
         instr_q   <= '0;
         total_q   <= '0;
         rd_data_q <= '0;
         state_q   <= IDLE;
      end else begin
         for (int i = 0; i < num_reasons_p; i++)
            reason_q[i] <= reason_d[i];
         instr_q   <= instr_d;
         total_q   <= total_d;
         rd_data_q <= rd_data_d;
         state_q   <= state_d;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_bp_stall_hist_counters.sv
// Bench for bp_stall_hist_counters: 32-bit and 4-bit counter instances
// share stimulus and are checked against a histogram model each cycle.
module tb_bp_stall_hist_counters;

   logic        clk = 1'b0;
   logic        reset_li = 1'b1;
   logic        en_i = 1'b0;
   logic        clear_i = 1'b0;
   logic        sample_v_i = 1'b0;
   logic        instret_i = 1'b0;
   logic [4:0]  reason_i = '0;
   logic        rd_v_i = 1'b0;
   logic [5:0]  rd_addr_i = '0;
   logic        rd_yumi_i = 1'b0;
   logic        rd_ready_o, rd_data_v_o;
   logic [31:0] rd_data_o;
   logic        rd_ready4, rd_data_v4;
   logic [31:0] rd_data4;

   int checks = 0;
   int failures = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   bp_stall_hist_counters #(.num_reasons_p(30), .cnt_width_p(32), .addr_width_p(6)) dut (
      .clk_i(clk), .reset_li(reset_li), .en_i(en_i), .clear_i(clear_i),
      .sample_v_i(sample_v_i), .instret_i(instret_i), .reason_i(reason_i),
      .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
      .rd_data_v_o(rd_data_v_o), .rd_data_o(rd_data_o), .rd_yumi_i(rd_yumi_i)
   );

   bp_stall_hist_counters #(.num_reasons_p(30), .cnt_width_p(4), .addr_width_p(6)) dut4 (
      .clk_i(clk), .reset_li(reset_li), .en_i(en_i), .clear_i(clear_i),
      .sample_v_i(sample_v_i), .instret_i(instret_i), .reason_i(reason_i),
      .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready4),
      .rd_data_v_o(rd_data_v4), .rd_data_o(rd_data4), .rd_yumi_i(rd_yumi_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Histogram model: address-indexed bins, index 0 of m is the 32-bit
   // instance, index 1 the 4-bit one.
   longint unsigned m [2][32];
   longint unsigned mmax [2] = '{64'hFFFF_FFFF, 64'd15};
   bit              mresp;
   logic [31:0]     mexp [2];

   function automatic void bump(input int k, input int a);
      if (m[k][a] < mmax[k]) m[k][a] = m[k][a] + 1;
   endfunction

   always @(posedge clk or negedge reset_li) begin
      if (!reset_li) begin
         for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 32; a++) m[k][a] = 0;
            mexp[k] = '0;
         end
         mresp = 1'b0;
      end else begin
         if (!mresp && rd_v_i) begin
            for (int k = 0; k < 2; k++)
               mexp[k] = (rd_addr_i < 32) ? 32'(m[k][rd_addr_i[4:0]]) : 32'd0;
            mresp = 1'b1;
         end else if (mresp && rd_yumi_i) begin
            mresp = 1'b0;
         end
         if (clear_i) begin
            for (int k = 0; k < 2; k++)
               for (int a = 0; a < 32; a++) m[k][a] = 0;
         end else if (sample_v_i && en_i) begin
            for (int k = 0; k < 2; k++) begin
               bump(k, 31);
               if (instret_i) bump(k, 30);
               else bump(k, (reason_i < 30) ? int'(reason_i) : 0);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cmp_ready", {31'd0, rd_ready_o}, {31'd0, !mresp});
         chk("cmp_dv", {31'd0, rd_data_v_o}, {31'd0, mresp});
         chk("cmp_data", rd_data_o, mexp[0]);
         chk("cmp_ready4", {31'd0, rd_ready4}, {31'd0, !mresp});
         chk("cmp_dv4", {31'd0, rd_data_v4}, {31'd0, mresp});
         chk("cmp_data4", rd_data4, mexp[1]);
      end
   end

   task automatic samp(input int n, input bit ins, input int r);
      repeat (n) begin
         sample_v_i = 1'b1;
         instret_i  = ins;
         reason_i   = 5'(r);
         @(negedge clk);
      end
      sample_v_i = 1'b0;
      instret_i  = 1'b0;
   endtask

   task automatic clr();
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
   endtask

   task automatic rd(input int a, input logic [31:0] e, input logic [31:0] e4);
      int n;
      n = 0;
      while (!rd_ready_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rd_ready_wait", {31'd0, rd_ready_o}, 32'd1);
      rd_v_i    = 1'b1;
      rd_addr_i = 6'(a);
      @(negedge clk);
      rd_v_i = 1'b0;
      chk($sformatf("rd_addr%0d", a), rd_data_o, e);
      chk($sformatf("rd4_addr%0d", a), rd_data4, e4);
      rd_yumi_i = 1'b1;
      @(negedge clk);
      rd_yumi_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      #1 reset_li = 1'b0;
      repeat (2) @(negedge clk);
      reset_li = 1'b1;
      started  = 1'b1;
      chk("rst_ready", {31'd0, rd_ready_o}, 32'd1);
      chk("rst_dv", {31'd0, rd_data_v_o}, 32'd0);
      chk("rst_data", rd_data_o, 32'd0);

      // basic histogram
      en_i = 1'b1;
      samp(5, 1'b0, 2);
      samp(3, 1'b1, 0);
      rd(2, 5, 5);
      rd(30, 3, 3);
      rd(31, 8, 8);
      rd(5, 0, 0);

      // out-of-range reason folds into bin 0
      clr();
      samp(1, 1'b0, 31);
      samp(1, 1'b0, 29);
      rd(0, 1, 1);
      rd(29, 1, 1);
      rd(31, 2, 2);

      // clear honoured with en low, then saturation on the 4-bit instance
      en_i = 1'b0;
      clr();
      en_i = 1'b1;
      rd(31, 0, 0);
      samp(20, 1'b0, 7);
      rd(7, 20, 15);
      rd(31, 20, 15);

      // en low drops samples; clear beats a simultaneous sample
      en_i = 1'b0;
      samp(1, 1'b0, 3);
      en_i = 1'b1;
      clear_i = 1'b1;
      samp(1, 1'b0, 3);
      clear_i = 1'b0;
      for (int a = 0; a < 32; a++) rd(a, 0, 0);

      // read racing a sample to the same counter, response held
      samp(10, 1'b0, 4);
      rd_v_i = 1'b1;
      rd_addr_i = 6'd4;
      sample_v_i = 1'b1;
      reason_i = 5'd4;
      @(negedge clk);
      rd_v_i = 1'b0;
      reason_i = 5'd6;
      for (int i = 0; i < 3; i++) begin
         chk("hold_data", rd_data_o, 32'd10);
         chk("hold_data4", rd_data4, 32'd10);
         chk("hold_ready", {31'd0, rd_ready_o}, 32'd0);
         @(negedge clk);
      end
      sample_v_i = 1'b0;
      rd_yumi_i = 1'b1;
      rd_v_i = 1'b1;
      @(negedge clk);
      rd_yumi_i = 1'b0;
      chk("yumi_gap_dv", {31'd0, rd_data_v_o}, 32'd0);
      chk("yumi_gap_data", rd_data_o, 32'd10);
      @(negedge clk);
      rd_v_i = 1'b0;
      chk("reread4", rd_data_o, 32'd11);
      rd_yumi_i = 1'b1;
      @(negedge clk);
      rd_yumi_i = 1'b0;
      rd(40, 0, 0);
      rd_yumi_i = 1'b1;
      @(negedge clk);
      rd_yumi_i = 1'b0;
      chk("stray_yumi_dv", {31'd0, rd_data_v_o}, 32'd0);
      rd(6, 3, 3);

      // asynchronous reset in the middle of a response
      rd_v_i = 1'b1;
      rd_addr_i = 6'd4;
      @(negedge clk);
      rd_v_i = 1'b0;
      chk("pre_rst_dv", {31'd0, rd_data_v_o}, 32'd1);
      #1 reset_li = 1'b0;
      #1;
      chk("arst_dv", {31'd0, rd_data_v_o}, 32'd0);
      chk("arst_ready", {31'd0, rd_ready_o}, 32'd1);
      chk("arst_data", rd_data_o, 32'd0);
      chk("arst_data4", rd_data4, 32'd0);
      @(negedge clk);
      reset_li = 1'b1;
      rd(4, 0, 0);
      rd(31, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
